// File: rtl/sc_lane_scheduler.sv
// Frogger obstacle-lane scheduler: a programmable tick starts a sweep that strobes each lane
// once, in order. Each sweep ends with a collision-check pulse. Sweeps stall behind frog updates.
module sc_lane_scheduler #(
    parameter int NUM_LANES    = 4,
    parameter int TICK_WIDTH   = 24,
    parameter int BASE_PERIOD  = 5000000,
    parameter int MIN_PERIOD   = 1000000,
    parameter int SPEEDUP_STEP = 500000
) (
    input  logic                 SC_LANESCHEDULER_CLOCK_50,
    input  logic                 SC_LANESCHEDULER_RESET_InHigh,
    input  logic                 SC_LANESCHEDULER_startGame_InLow,
    input  logic                 SC_LANESCHEDULER_gameOver_InHigh,
    input  logic                 SC_LANESCHEDULER_levelUp_InHigh,
    input  logic                 SC_LANESCHEDULER_frogBusy_InHigh,
    input  logic [NUM_LANES-1:0] SC_LANESCHEDULER_laneDirection_In,
    output logic [NUM_LANES-1:0] SC_LANESCHEDULER_laneShift_OutLow,
    output logic [1:0]           SC_LANESCHEDULER_shiftselection_Out,
    output logic                 SC_LANESCHEDULER_collisionCheck_OutHigh,
    output logic                 SC_LANESCHEDULER_running_OutHigh,
    output logic [3:0]           SC_LANESCHEDULER_level_Out
);

    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    localparam logic [TICK_WIDTH-1:0] BASE_P   = TICK_WIDTH'(BASE_PERIOD);
    localparam logic [TICK_WIDTH-1:0] MIN_P    = TICK_WIDTH'(MIN_PERIOD);
    localparam logic [TICK_WIDTH-1:0] ONE_T    = TICK_WIDTH'(1);
    localparam logic [TICK_WIDTH:0]   STEP_W   = (TICK_WIDTH + 1)'(SPEEDUP_STEP);
    localparam logic [TICK_WIDTH:0]   SAT_W    = (TICK_WIDTH + 1)'(SPEEDUP_STEP + MIN_PERIOD);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_LANES - 1);
    localparam logic [IDX_W-1:0]      ONE_IDX  = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_SHIFT,
        S_CHECK,
        S_STOPPED
    } state_e;

    logic                  clk;
    logic                  rst;
    logic                  start_n;
    logic                  game_over;
    logic                  level_up;
    logic                  frog_busy;
    logic [NUM_LANES-1:0]  lane_dir;

    state_e                state_q, state_d;
    logic [TICK_WIDTH-1:0] count_q, count_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [TICK_WIDTH-1:0] period_q, period_d;
    logic [3:0]            level_q, level_d;

    logic                  active;
    logic [TICK_WIDTH:0]   period_ext;
    logic [TICK_WIDTH:0]   period_dec;
    logic [TICK_WIDTH-1:0] sped_period;
    logic [NUM_LANES-1:0]  lane_shift_n;
    logic [1:0]            shift_sel;
    logic                  collision;

    assign clk       = SC_LANESCHEDULER_CLOCK_50;
    assign rst       = SC_LANESCHEDULER_RESET_InHigh;
    assign start_n   = SC_LANESCHEDULER_startGame_InLow;
    assign game_over = SC_LANESCHEDULER_gameOver_InHigh;
    assign level_up  = SC_LANESCHEDULER_levelUp_InHigh;
    assign frog_busy = SC_LANESCHEDULER_frogBusy_InHigh;
    assign lane_dir  = SC_LANESCHEDULER_laneDirection_In;

    assign active = (state_q == S_WAIT_TICK) || (state_q == S_SHIFT) || (state_q == S_CHECK);

    // One extra bit of headroom, so a small period saturates to the floor instead of wrapping.
    assign period_ext  = {1'b0, period_q};
    assign period_dec  = period_ext - STEP_W;
    assign sped_period = (period_ext < SAT_W) ? MIN_P : period_dec[TICK_WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments only; the next-state logic lives in always_comb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            idx_q    <= '0;
            period_q <= BASE_P;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            period_q <= period_d;
            level_q  <= level_d;
        end
    end

    // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        idx_d        = idx_q;
        period_d     = period_q;
        level_d      = level_q;
        lane_shift_n = '1;
        shift_sel    = 2'b11;
        collision    = 1'b0;

        if (active && level_up && !game_over) begin
            period_d = sped_period;
            level_d  = (level_q == 4'hF) ? level_q : level_q + 4'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!start_n && !game_over) begin
                    state_d  = S_WAIT_TICK;
                    count_d  = '0;
                    idx_d    = '0;
                    period_d = BASE_P;
                    level_d  = '0;
                end
            end
            S_WAIT_TICK: begin
                if (game_over) begin
                    state_d = S_STOPPED;
                end else if (count_q >= period_q - ONE_T) begin
                    count_d = '0;
                    idx_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    count_d = count_q + ONE_T;
                end
            end
            S_SHIFT: begin
                if (game_over) begin
                    state_d = S_STOPPED;
                end else if (!frog_busy) begin
                    lane_shift_n[idx_q] = 1'b0;
                    shift_sel           = lane_dir[idx_q] ? 2'b01 : 2'b10;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_CHECK;
                    end else begin
                        idx_d = idx_q + ONE_IDX;
                    end
                end
            end
            S_CHECK: begin
                if (game_over) begin
                    state_d = S_STOPPED;
                end else begin
                    collision = 1'b1;
                    count_d   = '0;
                    state_d   = S_WAIT_TICK;
                end
            end
            S_STOPPED: begin
                // Returning only on release stops a held start button from restarting the game.
                if (start_n) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign SC_LANESCHEDULER_laneShift_OutLow       = lane_shift_n;
    assign SC_LANESCHEDULER_shiftselection_Out     = shift_sel;
    assign SC_LANESCHEDULER_collisionCheck_OutHigh = collision;
    assign SC_LANESCHEDULER_running_OutHigh        = active;
    assign SC_LANESCHEDULER_level_Out              = level_q;

endmodule

// File: tb/tb_sc_lane_scheduler.sv
// Self-checking bench for sc_lane_scheduler: expected lane strobes and collision pulses are queued
// with their cycle numbers when stimulus is set up, then popped and compared as the DUT emits them.
module tb_sc_lane_scheduler;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       start_n   = 1'b1;
    logic       game_over = 1'b0;
    logic       level_up  = 1'b0;
    logic       frog_busy = 1'b0;
    logic [3:0] lane_dir  = 4'b1111;

    logic [3:0] lane_shift;
    logic [1:0] shift_sel;
    logic       coll;
    logic       running;
    logic [3:0] level;

    int cyc      = 0;
    int c0       = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         cyc;
        logic [3:0] lane;
        logic [1:0] sel;
        logic       coll;
    } evt_t;

    evt_t exp_q[$];

    sc_lane_scheduler #(
        .NUM_LANES   (4),
        .TICK_WIDTH  (24),
        .BASE_PERIOD (8),
        .MIN_PERIOD  (4),
        .SPEEDUP_STEP(2)
    ) dut (
        .SC_LANESCHEDULER_CLOCK_50              (clk),
        .SC_LANESCHEDULER_RESET_InHigh          (rst),
        .SC_LANESCHEDULER_startGame_InLow       (start_n),
        .SC_LANESCHEDULER_gameOver_InHigh       (game_over),
        .SC_LANESCHEDULER_levelUp_InHigh        (level_up),
        .SC_LANESCHEDULER_frogBusy_InHigh       (frog_busy),
        .SC_LANESCHEDULER_laneDirection_In      (lane_dir),
        .SC_LANESCHEDULER_laneShift_OutLow      (lane_shift),
        .SC_LANESCHEDULER_shiftselection_Out    (shift_sel),
        .SC_LANESCHEDULER_collisionCheck_OutHigh(coll),
        .SC_LANESCHEDULER_running_OutHigh       (running),
        .SC_LANESCHEDULER_level_Out             (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_strobe(input int at, input int lane, input logic [3:0] dir);
        evt_t e;
        e.cyc  = at;
        e.lane = ~(4'b0001 << lane);
        e.sel  = dir[lane] ? 2'b01 : 2'b10;
        e.coll = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_check(input int at);
        evt_t e;
        e.cyc  = at;
        e.lane = 4'hF;
        e.sel  = 2'b11;
        e.coll = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_sweep(input int at, input logic [3:0] dir);
        for (int i = 0; i < 4; i++) push_strobe(at + i, i, dir);
        push_check(at + 4);
    endtask

    // Advance to cycle c0+t, landing just after the active edge so inputs settle before sampling.
    task automatic step_to(input int t);
        while (cyc < c0 + t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor samples on the falling edge, away from the edge that updates the DUT.
    always @(negedge clk) begin : monitor
        evt_t e;
        if (lane_shift != 4'hF || coll) begin
            if (exp_q.size() == 0) begin
                check("spurious_evt", {25'd0, coll, shift_sel, lane_shift}, 32'h3F);
            end else begin
                e = exp_q.pop_front();
                check("evt_cycle", 32'(cyc), 32'(e.cyc));
                check("evt_lane", 32'(lane_shift), 32'(e.lane));
                check("evt_sel", 32'(shift_sel), 32'(e.sel));
                check("evt_coll", 32'(coll), 32'(e.coll));
            end
        end else begin
            check("idle_sel", 32'(shift_sel), 32'h3);
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check("missed_evt", {25'd0, coll, shift_sel, lane_shift},
                      {25'd0, e.coll, e.sel, e.lane});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_lane", 32'(lane_shift), 32'hF);
        check("rst_sel", 32'(shift_sel), 32'h3);
        check("rst_coll", 32'(coll), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        rst = 1'b0;

        // Basic sweep, all lanes shifting left; next sweep 13 cycles later.
        @(posedge clk);
        #1;
        c0      = cyc;
        start_n = 1'b0;
        push_sweep(c0 + 9, 4'b1111);
        step_to(1);
        start_n = 1'b1;
        check("start_running", 32'(running), 32'h1);
        check("start_level", 32'(level), 32'h0);

        // Mixed directions.
        step_to(14);
        lane_dir = 4'b0101;
        push_sweep(c0 + 22, 4'b0101);

        // Frog busy for three cycles at the lane-1 slot.
        step_to(27);
        push_strobe(c0 + 35, 0, lane_dir);
        push_strobe(c0 + 39, 1, lane_dir);
        push_strobe(c0 + 40, 2, lane_dir);
        push_strobe(c0 + 41, 3, lane_dir);
        push_check(c0 + 42);
        step_to(36);
        frog_busy = 1'b1;
        step_to(39);
        frog_busy = 1'b0;

        // Four level-ups: period 8 -> 6 -> 4 -> 4 -> 4, interval shrinks from 13 to 9.
        step_to(43);
        push_sweep(c0 + 51, lane_dir);
        push_sweep(c0 + 60, lane_dir);
        push_sweep(c0 + 69, lane_dir);
        push_strobe(c0 + 78, 0, lane_dir);
        push_strobe(c0 + 79, 1, lane_dir);
        for (int i = 0; i < 4; i++) begin
            step_to(51 + 2 * i);
            level_up = 1'b1;
            step_to(52 + 2 * i);
            level_up = 1'b0;
            check("level_step", 32'(level), 32'(i + 1));
        end

        // Level saturates at 15 while the period stays at its floor.
        step_to(60);
        level_up = 1'b1;
        step_to(70);
        check("level_14", 32'(level), 32'd14);
        step_to(71);
        check("level_15", 32'(level), 32'd15);
        step_to(72);
        level_up = 1'b0;
        check("level_sat", 32'(level), 32'd15);

        // Game over at the lane-2 slot, start held low while stopped.
        step_to(80);
        game_over = 1'b1;
        start_n   = 1'b0;
        step_to(81);
        game_over = 1'b0;
        check("stop_running", 32'(running), 32'h0);
        step_to(82);
        level_up = 1'b1;
        step_to(83);
        level_up = 1'b0;
        check("stop_level_frozen", 32'(level), 32'd15);
        check("stop_held_start", 32'(running), 32'h0);
        step_to(85);
        start_n = 1'b1;
        step_to(86);
        start_n   = 1'b0;
        game_over = 1'b1;
        step_to(87);
        game_over = 1'b0;
        check("idle_gameover_blocks", 32'(running), 32'h0);
        push_strobe(c0 + 96, 0, lane_dir);
        push_strobe(c0 + 97, 1, lane_dir);
        step_to(88);
        start_n = 1'b1;
        check("restart_running", 32'(running), 32'h1);
        check("restart_level", 32'(level), 32'h0);

        // Asynchronous reset in the lane-2 slot of the restarted sweep.
        step_to(98);
        rst = 1'b1;
        #1;
        check("arst_lane", 32'(lane_shift), 32'hF);
        check("arst_sel", 32'(shift_sel), 32'h3);
        check("arst_coll", 32'(coll), 32'h0);
        check("arst_running", 32'(running), 32'h0);
        check("arst_level", 32'(level), 32'h0);
        step_to(100);
        rst = 1'b0;
        step_to(120);
        check("post_rst_idle", 32'(running), 32'h0);
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sc_lane_scheduler.md
Name: sc_lane_scheduler

Overview:
- Sequences the periodic scrolling of the Frogger obstacle lanes (car/log shift registers).
- A programmable time base triggers a sweep. Each sweep issues one shift strobe per lane, in order, with a per-lane direction, then pulses a collision-check request.
- Shares the playfield update path with the frog-movement controller: lane strobes stall while a frog load/shift is in progress.
- Speed rises on level-up and stops on game over.

Parameters:
NUM_LANES, 4, number of obstacle lanes (one strobe bit each)
TICK_WIDTH, 24, width of tick counter and period register
BASE_PERIOD, 5000000, WAIT_TICK cycles per sweep at level 0 (0.1 s at 50 MHz)
MIN_PERIOD, 1000000, floor for the period after speed-ups
SPEEDUP_STEP, 500000, period decrement per level-up

Ports:
SC_LANESCHEDULER_CLOCK_50  in  1  system clock
SC_LANESCHEDULER_RESET_InHigh  in  1  asynchronous active-high reset
SC_LANESCHEDULER_startGame_InLow  in  1  start request, active low (level)
SC_LANESCHEDULER_gameOver_InHigh  in  1  stop request, active high (level)
SC_LANESCHEDULER_levelUp_InHigh  in  1  one-cycle pulse, speed up one level
SC_LANESCHEDULER_frogBusy_InHigh  in  1  frog controller driving load/shift this cycle
SC_LANESCHEDULER_laneDirection_In  in  NUM_LANES  per-lane direction; 1 = left, 0 = right
SC_LANESCHEDULER_laneShift_OutLow  out  NUM_LANES  one-cold lane shift strobe
SC_LANESCHEDULER_shiftselection_Out  out  2  01 = left, 10 = right, 11 = hold
SC_LANESCHEDULER_collisionCheck_OutHigh  out  1  one-cycle pulse after a completed sweep
SC_LANESCHEDULER_running_OutHigh  out  1  scheduler active
SC_LANESCHEDULER_level_Out  out  4  current level, saturating at 15

Behaviour:
Reset (async, immediate), all outputs and registers:
- state IDLE
- tick count 0
- lane index 0
- period BASE_PERIOD
- level 0
- laneShift all 1s
- shiftselection 11
- collisionCheck 0
- running 0

States:
- IDLE: counters held. startGame_InLow == 0 sampled → WAIT_TICK; on entry period reloads to BASE_PERIOD and level to 0.
- WAIT_TICK: count increments each cycle. When count >= period-1, count clears, lane index clears, → SHIFT. Using >= means a period shrinking below the current count fires at the next cycle.
- SHIFT: one lane per cycle.
  - If frogBusy_InHigh == 1: no strobe, index holds (stall).
  - Else: laneShift[index] = 0 and shiftselection from laneDirection[index] (1 → 01, 0 → 10), combinationally in that cycle; index increments.
  - After the strobe for lane NUM_LANES-1 → CHECK.
  - Stalls are unbounded; no lane is ever skipped or repeated.
- CHECK: collisionCheck_OutHigh = 1 for exactly one cycle → WAIT_TICK; count starts from 0.
- STOPPED: all strobes inactive, running 0, period and level frozen. → IDLE when startGame_InLow == 1. A held start button therefore cannot auto-restart.

Outputs and priority:
- running_OutHigh = 1 in WAIT_TICK, SHIFT and CHECK.
- gameOver_InHigh == 1 in WAIT_TICK, SHIFT or CHECK:
  - next state is STOPPED;
  - the strobe and collisionCheck are suppressed in that same cycle;
  - a partial sweep is abandoned.
- gameOver has priority over frogBusy and over tick expiry.
- gameOver in IDLE has no effect; start is ignored while gameOver == 1.

Level-up:
- Honoured only in WAIT_TICK, SHIFT and CHECK; ignored in IDLE and STOPPED.
- period <= (period - SPEEDUP_STEP < MIN_PERIOD) ? MIN_PERIOD : period - SPEEDUP_STEP. Computed at TICK_WIDTH+1 bits, so no underflow wrap.
- level <= level + 1, saturating at 15 independently of period saturation.
- levelUp coincident with gameOver: gameOver wins and level is unchanged.

Timing and widths:
- Sweep-to-sweep interval with no stalls = period + NUM_LANES + 1 cycles.
- Lane index width is clog2(NUM_LANES), minimum 1.
- laneShift is never more than one-cold.
- shiftselection = 11 whenever no strobe is active.

Test Plan:
(Parameters: NUM_LANES = 4, BASE_PERIOD = 8, MIN_PERIOD = 4, SPEEDUP_STEP = 2.)
1. Reset, startGame low 1 cycle, laneDirection = 1111 → running 1; after 8 WAIT cycles, laneShift 1110, 1101, 1011, 0111 on consecutive cycles with shiftselection 01; then collisionCheck 1 for one cycle; the next sweep starts 13 cycles after the first.
2. laneDirection = 0101 → shiftselection 01, 10, 01, 10 for lanes 0–3; 11 outside strobes.
3. frogBusy high 3 cycles starting at the lane-1 slot → laneShift stays 1111 for 3 cycles, then 1101, 1011, 0111; exactly 4 strobes per sweep.
4. Four levelUp pulses while running → period 6, 4, 4, 4; level_Out 1, 2, 3, 4; sweep interval becomes 9 cycles.
5. gameOver high during the lane-2 slot → no lane-2/lane-3 strobe, no collisionCheck, running 0 next cycle. Holding startGame low keeps it STOPPED; release then press restarts with period 8 and level 0.
6. RESET high mid-sweep (after the lane-1 strobe) → all outputs at reset values in the same cycle (async). After release, state is IDLE and no strobes occur until startGame.
